// File: rtl/video_row_prefetcher_pkg.sv
// Shared constants and types for the video row prefetcher.
package video_pkg;

   localparam int unsigned WIDTH        = 1024;
   localparam int unsigned HEIGHT       = 600;
   localparam int unsigned PIXEL_BITS   = 16;
   localparam int unsigned ROW_BITS     = 10;
   localparam int unsigned READ_LATENCY = 4;
   localparam int unsigned ACK_DEADLINE = 4;
   localparam int unsigned ADDR_BITS    = $clog2(WIDTH);
   localparam int unsigned AGE_BITS     = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      RECEIVE = 2'd2
   } fetch_state_t;

   typedef logic [PIXEL_BITS-1:0] pixel_t;

endpackage

// File: rtl/video_row_prefetcher_if.sv
// Row-fetch bus between the prefetcher (master) and the frame-memory arbiter (slave).
interface video_row_prefetcher_if;
   import video_pkg::*;

   logic                o_fetch_request;
   logic [ROW_BITS-1:0] o_fetch_row;
   logic                i_fetch_ack;
   logic                i_fetch_valid;
   pixel_t              i_fetch_data;

   modport master (
      output o_fetch_request,
      output o_fetch_row,
      input  i_fetch_ack,
      input  i_fetch_valid,
      input  i_fetch_data
   );

   modport slave (
      input  o_fetch_request,
      input  o_fetch_row,
      output i_fetch_ack,
      output i_fetch_valid,
      output i_fetch_data
   );

endinterface

// File: rtl/video_row_prefetcher_line_buffer_ram.sv
// Ping-pong line buffer: simple dual-port RAM, bank select is the address MSB.
module line_buffer_ram
   import video_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS:0]   i_waddr,
   input  pixel_t               i_wdata,
   input  logic [ADDR_BITS:0]   i_raddr,
   output pixel_t               o_rdata
);

   pixel_t r_mem [2*WIDTH];

   // Write port plus registered read port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/video_row_prefetcher.sv
// Fetches one row per scan line into a ping-pong buffer and streams it out pixel-aligned.
module video_row_prefetcher
   import video_pkg::*;
(
   input  logic                          i_pixel_clk,
   input  logic                          i_reset,
   input  logic                          i_timing_pixel_first,
   input  logic                          i_timing_pixel_last,
   input  logic                          i_timing_blank,
   input  logic                          i_timing_prefetch_start,
   input  logic                          i_timing_prefetch_strobe_end,
   input  logic                          i_timing_prefetch_row_first_render,
   input  logic                          i_timing_prefetch_row_last_render,
   video_row_prefetcher_if.master        fetch_if,
   output pixel_t                        o_pixel_data,
   output logic                          o_underrun
);

   fetch_state_t          r_state;
   fetch_state_t          w_next_state;
   logic [ROW_BITS-1:0]   r_row;
   logic [ROW_BITS-1:0]   w_next_row;
   logic                  r_frame_active;
   logic                  w_next_frame;
   logic                  r_wbank;
   logic [1:0]            r_bank_valid;
   logic [ADDR_BITS-1:0]  r_waddr;
   logic [AGE_BITS-1:0]   r_req_age;
   logic                  r_underrun;

   logic                  w_fetch;
   logic                  w_set_underrun;
   logic                  w_ack_accept;
   logic                  w_we;
   logic                  w_fill_done;

   logic                  r_rd_active;
   logic [ADDR_BITS-1:0]  r_raddr;
   logic [READ_LATENCY-1:0] r_ok_pipe;
   pixel_t                r_pix_pipe [READ_LATENCY-1];
   pixel_t                w_ram_rdata;
   logic                  w_rd_bank;
   logic                  w_rd_bank_valid;
   logic                  w_rd_ok;
   logic                  w_rd_underrun;

   assign w_rd_bank       = ~r_wbank;
   assign w_rd_bank_valid = r_bank_valid[w_rd_bank];
   assign w_rd_ok         = r_rd_active && w_rd_bank_valid;
   assign w_rd_underrun   = r_rd_active && !w_rd_bank_valid;

   // Fetch FSM state register
   always_ff @(posedge i_pixel_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, per-line fetch decision and fill-side strobes
   always_comb begin
      w_next_state   = r_state;
      w_next_row     = r_row;
      w_next_frame   = r_frame_active;
      w_fetch        = 1'b0;
      w_set_underrun = 1'b0;
      w_ack_accept   = 1'b0;
      w_we           = 1'b0;
      w_fill_done    = 1'b0;

      if (i_timing_prefetch_start) begin
         // A new line always wins; an unfinished fetch is abandoned as late
         if (r_state != IDLE) begin
            w_set_underrun = 1'b1;
         end
         w_next_state = IDLE;
         if (i_timing_prefetch_row_first_render) begin
            w_next_row   = '0;
            w_next_frame = 1'b1;
            w_fetch      = 1'b1;
         end else if (i_timing_prefetch_row_last_render) begin
            w_next_frame = 1'b0;
         end else if (r_frame_active) begin
            if (r_row < ROW_BITS'(HEIGHT - 1)) begin
               w_next_row = r_row + 1'b1;
            end
            w_fetch = 1'b1;
         end
         if (w_fetch) begin
            w_next_state = REQUEST;
         end
      end else begin
         case (r_state)
            REQUEST: begin
               if (fetch_if.i_fetch_ack) begin
                  w_ack_accept = 1'b1;
                  w_next_state = RECEIVE;
               end else if (i_timing_prefetch_strobe_end ||
                            r_req_age == AGE_BITS'(ACK_DEADLINE - 1)) begin
                  w_set_underrun = 1'b1;
                  w_next_state   = IDLE;
               end
            end
            RECEIVE: begin
               if (fetch_if.i_fetch_valid) begin
                  w_we = 1'b1;
                  if (r_waddr == ADDR_BITS'(WIDTH - 1)) begin
                     w_fill_done  = 1'b1;
                     w_next_state = IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Row counter, bank bookkeeping, write address and sticky underrun
   always_ff @(posedge i_pixel_clk) begin
      if (i_reset) begin
         r_row          <= '0;
         r_frame_active <= 1'b0;
         r_wbank        <= 1'b0;
         r_bank_valid   <= '0;
         r_waddr        <= '0;
         r_req_age      <= '0;
         r_underrun     <= 1'b0;
      end else begin
         r_row          <= w_next_row;
         r_frame_active <= w_next_frame;
         if (w_set_underrun || w_rd_underrun) begin
            r_underrun <= 1'b1;
         end
         if (w_fetch) begin
            r_wbank                <= ~r_wbank;
            r_bank_valid[~r_wbank] <= 1'b0;
         end else if (w_fill_done) begin
            r_bank_valid[r_wbank] <= 1'b1;
         end
         if (w_fetch) begin
            r_req_age <= '0;
         end else if (r_state == REQUEST) begin
            r_req_age <= r_req_age + 1'b1;
         end
         if (w_ack_accept) begin
            r_waddr <= '0;
         end else if (w_we && !w_fill_done) begin
            r_waddr <= r_waddr + 1'b1;
         end
      end
   end

   // Read address sequencing and the pixel/validity delay line
   always_ff @(posedge i_pixel_clk) begin
      if (i_reset) begin
         r_rd_active <= 1'b0;
         r_raddr     <= '0;
         r_ok_pipe   <= '0;
         for (int i = 0; i < READ_LATENCY - 1; i++) begin
            r_pix_pipe[i] <= '0;
         end
      end else begin
         if (i_timing_pixel_first) begin
            r_rd_active <= 1'b1;
            r_raddr     <= '0;
         end else if (r_rd_active) begin
            if (i_timing_pixel_last || r_raddr == ADDR_BITS'(WIDTH - 1)) begin
               r_rd_active <= 1'b0;
            end else begin
               r_raddr <= r_raddr + 1'b1;
            end
         end
         r_ok_pipe     <= {r_ok_pipe[READ_LATENCY-2:0], w_rd_ok};
         r_pix_pipe[0] <= w_ram_rdata;
         for (int i = 1; i < READ_LATENCY - 1; i++) begin
            r_pix_pipe[i] <= r_pix_pipe[i-1];
         end
      end
   end

   line_buffer_ram u_ram (
      .i_clk   (i_pixel_clk),
      .i_we    (w_we),
      .i_waddr ({r_wbank, r_waddr}),
      .i_wdata (fetch_if.i_fetch_data),
      .i_raddr ({w_rd_bank, r_raddr}),
      .o_rdata (w_ram_rdata)
   );

   assign fetch_if.o_fetch_request = (r_state == REQUEST);
   assign fetch_if.o_fetch_row     = r_row;
   assign o_underrun               = r_underrun;
   // Blank is a same-cycle command from the timing controller
   assign o_pixel_data = (r_ok_pipe[READ_LATENCY-1] && !i_timing_blank) ?
                         r_pix_pipe[READ_LATENCY-2] : '0;

endmodule
